// File: rtl/branch_rs_scheduler.sv
// Branch reservation station and issue scheduler for the shared branch ALU.
// Holds dispatched conditional branches in a compacting age-ordered queue
// (slot 0 oldest), snoops the CDB for missing operands, issues the oldest
// fully ready entry to the ALU and registers the resolved result for the ROB.
// Optional build macro: BRANCH_SCHED_PERF_EN adds issue/stall counters.
module branch_rs_scheduler #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             alloc_valid,
   output logic             alloc_ready,
   input  logic [2:0]       alloc_op,
   input  logic [TAG_W-1:0] alloc_rob_tag,
   input  logic [31:0]      alloc_pc,
   input  logic [31:0]      alloc_imm,
   input  logic             alloc_rs1_rdy,
   input  logic [TAG_W-1:0] alloc_rs1_tag,
   input  logic [31:0]      alloc_rs1_val,
   input  logic             alloc_rs2_rdy,
   input  logic [TAG_W-1:0] alloc_rs2_tag,
   input  logic [31:0]      alloc_rs2_val,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [31:0]      cdb_value,
   output logic [2:0]       alu_op,
   output logic [31:0]      alu_first,
   output logic [31:0]      alu_second,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   input  logic             alu_answer,
   input  logic [31:0]      alu_address,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [TAG_W-1:0] res_rob_tag,
   output logic             res_taken,
   output logic [31:0]      res_target
`ifdef BRANCH_SCHED_PERF_EN
   ,
   output logic [31:0]      perf_issue_cnt,
   output logic [31:0]      perf_stall_cnt
`endif
);

   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [2:0]       op;
      logic [TAG_W-1:0] rob_tag;
      logic [31:0]      pc;
      logic [31:0]      imm;
      logic             rs1_rdy;
      logic [TAG_W-1:0] rs1_tag;
      logic [31:0]      rs1_val;
      logic             rs2_rdy;
      logic [TAG_W-1:0] rs2_tag;
      logic [31:0]      rs2_val;
   } ent_t;

   ent_t             ent     [DEPTH];
   ent_t             woke    [DEPTH];
   ent_t             ent_nxt [DEPTH];
   ent_t             new_ent;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_nxt;
   logic [CW-1:0]    sel;
   logic [CW-1:0]    slot;
   logic [DEPTH-1:0] opnd_rdy;
   logic             can_issue;
   logic             issue;
   logic             alloc_fire;

   assign alloc_ready = (count < CW'(DEPTH));
   assign alloc_fire  = alloc_valid & alloc_ready;
   assign can_issue   = ~res_valid | res_ready;

   // CDB wakeup of stored entries; readiness for issue uses registered state only
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         woke[i] = ent[i];
         if (cdb_valid && !ent[i].rs1_rdy && ent[i].rs1_tag == cdb_tag) begin
            woke[i].rs1_rdy = 1'b1;
            woke[i].rs1_val = cdb_value;
         end
         if (cdb_valid && !ent[i].rs2_rdy && ent[i].rs2_tag == cdb_tag) begin
            woke[i].rs2_rdy = 1'b1;
            woke[i].rs2_val = cdb_value;
         end
         opnd_rdy[i] = (CW'(i) < count) && ent[i].rs1_rdy && ent[i].rs2_rdy;
      end
   end

   // Oldest-first pick: scan from the top so the lowest ready index wins
   always_comb begin
      issue = 1'b0;
      sel   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (opnd_rdy[i] && can_issue) begin
            issue = 1'b1;
            sel   = CW'(i);
         end
      end
   end

   // ALU operand mux; everything held at zero when nothing issues
   always_comb begin
      alu_op     = 3'b000;
      alu_first  = '0;
      alu_second = '0;
      alu_a      = '0;
      alu_b      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (issue && CW'(i) == sel) begin
            alu_op     = ent[i].op;
            alu_first  = ent[i].rs1_val;
            alu_second = ent[i].rs2_val;
            alu_a      = ent[i].pc;
            alu_b      = ent[i].imm;
         end
      end
   end

   // Incoming entry, including capture of a CDB broadcast in the same cycle
   always_comb begin
      new_ent.op      = alloc_op;
      new_ent.rob_tag = alloc_rob_tag;
      new_ent.pc      = alloc_pc;
      new_ent.imm     = alloc_imm;
      new_ent.rs1_rdy = alloc_rs1_rdy;
      new_ent.rs1_tag = alloc_rs1_tag;
      new_ent.rs1_val = alloc_rs1_val;
      new_ent.rs2_rdy = alloc_rs2_rdy;
      new_ent.rs2_tag = alloc_rs2_tag;
      new_ent.rs2_val = alloc_rs2_val;
      if (!alloc_rs1_rdy && cdb_valid && alloc_rs1_tag == cdb_tag) begin
         new_ent.rs1_rdy = 1'b1;
         new_ent.rs1_val = cdb_value;
      end
      if (!alloc_rs2_rdy && cdb_valid && alloc_rs2_tag == cdb_tag) begin
         new_ent.rs2_rdy = 1'b1;
         new_ent.rs2_val = cdb_value;
      end
   end

   // Next queue image: compact over the issued slot, then append at the tail
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_nxt[i] = woke[i];
      end
      for (int i = 0; i < DEPTH - 1; i++) begin
         if (issue && CW'(i) >= sel) begin
            ent_nxt[i] = woke[i+1];
         end
      end
      slot = count - CW'(issue);
      for (int i = 0; i < DEPTH; i++) begin
         if (alloc_fire && CW'(i) == slot) begin
            ent_nxt[i] = new_ent;
         end
      end
      count_nxt = count - CW'(issue) + CW'(alloc_fire);
   end

   // Occupancy; flush and reset empty the queue
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         count <= '0;
      end else begin
         count <= count_nxt;
      end
   end

   // Entry payload; slots at or above count are don't-care
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         ent[i] <= ent_nxt[i];
      end
   end

   // Result register: load on issue, drain on handshake, clear on flush
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         res_valid   <= 1'b0;
         res_rob_tag <= '0;
         res_taken   <= 1'b0;
         res_target  <= '0;
      end else if (issue) begin
         res_valid  <= 1'b1;
         res_taken  <= alu_answer;
         res_target <= alu_address;
         for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == sel) begin
               res_rob_tag <= ent[i].rob_tag;
            end
         end
      end else if (res_valid && res_ready) begin
         res_valid <= 1'b0;
      end
   end

`ifdef BRANCH_SCHED_PERF_EN
   logic stall;
   assign stall = (|opnd_rdy) & res_valid & ~res_ready;

   // Free-running counters; a squashed issue does not count, flush does not clear
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_issue_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (issue && !flush) begin
            perf_issue_cnt <= perf_issue_cnt + 32'd1;
         end
         if (stall) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_branch_rs_scheduler.sv
// Bench for branch_rs_scheduler: directed scenarios followed by random
// traffic, all compared each cycle against a queue-based reference model.
module tb_branch_rs_scheduler;

   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst, flush;
   logic             alloc_valid, alloc_ready;
   logic [2:0]       alloc_op;
   logic [TAG_W-1:0] alloc_rob_tag;
   logic [31:0]      alloc_pc, alloc_imm;
   logic             alloc_rs1_rdy, alloc_rs2_rdy;
   logic [TAG_W-1:0] alloc_rs1_tag, alloc_rs2_tag;
   logic [31:0]      alloc_rs1_val, alloc_rs2_val;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [31:0]      cdb_value;
   logic [2:0]       alu_op;
   logic [31:0]      alu_first, alu_second, alu_a, alu_b;
   logic             alu_answer;
   logic [31:0]      alu_address;
   logic             res_valid, res_ready;
   logic [TAG_W-1:0] res_rob_tag;
   logic             res_taken;
   logic [31:0]      res_target;
`ifdef BRANCH_SCHED_PERF_EN
   logic [31:0]      perf_issue_cnt, perf_stall_cnt;
`endif

   always #5 clk = ~clk;

   branch_rs_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_op(alloc_op),
      .alloc_rob_tag(alloc_rob_tag), .alloc_pc(alloc_pc), .alloc_imm(alloc_imm),
      .alloc_rs1_rdy(alloc_rs1_rdy), .alloc_rs1_tag(alloc_rs1_tag), .alloc_rs1_val(alloc_rs1_val),
      .alloc_rs2_rdy(alloc_rs2_rdy), .alloc_rs2_tag(alloc_rs2_tag), .alloc_rs2_val(alloc_rs2_val),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .alu_op(alu_op), .alu_first(alu_first), .alu_second(alu_second),
      .alu_a(alu_a), .alu_b(alu_b), .alu_answer(alu_answer), .alu_address(alu_address),
      .res_valid(res_valid), .res_ready(res_ready), .res_rob_tag(res_rob_tag),
      .res_taken(res_taken), .res_target(res_target)
`ifdef BRANCH_SCHED_PERF_EN
      , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   function automatic logic br_taken(logic [2:0] op, logic [31:0] a, logic [31:0] b);
      case (op)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return $signed(a) < $signed(b);
         3'b101:  return $signed(a) >= $signed(b);
         3'b110:  return a < b;
         3'b111:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   // Behavioural branch ALU
   assign alu_answer  = br_taken(alu_op, alu_first, alu_second);
   assign alu_address = alu_a + alu_b;

   always @(posedge clk) begin
      if (!rst && alloc_valid)
         assert (alloc_op inside {3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111})
            else $error("illegal alloc_op %b", alloc_op);
   end

   typedef struct {
      logic [2:0]       op;
      logic [TAG_W-1:0] tag;
      logic [31:0]      pc, imm;
      logic             r1_rdy, r2_rdy;
      logic [TAG_W-1:0] r1_tag, r2_tag;
      logic [31:0]      r1_val, r2_val;
   } m_ent_t;

   m_ent_t           q[$];
   logic             m_res_valid, m_res_taken;
   logic [TAG_W-1:0] m_res_tag;
   logic [31:0]      m_res_target;
   logic [31:0]      m_issue_cnt, m_stall_cnt;
   bit               m_known = 0;
   int               n_checks = 0;
   int               n_pass = 0;

   task automatic check(string name, logic [63:0] got, logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   // One clock: compare at negedge+1, advance the model at posedge, return at negedge
   task automatic cycle();
      int     idx;
      bit     fire, any_rdy;
      m_ent_t e;
      #1;
      idx = -1;
      if (!m_res_valid || res_ready)
         foreach (q[i]) if (idx < 0 && q[i].r1_rdy && q[i].r2_rdy) idx = i;
      if (m_known) begin
         check("alloc_ready", 64'(alloc_ready), 64'(q.size() < DEPTH));
         check("res_valid", 64'(res_valid), 64'(m_res_valid));
         check("res_rob_tag", 64'(res_rob_tag), 64'(m_res_tag));
         check("res_taken", 64'(res_taken), 64'(m_res_taken));
         check("res_target", 64'(res_target), 64'(m_res_target));
         check("alu_op", 64'(alu_op), idx < 0 ? 64'd0 : 64'(q[idx].op));
         check("alu_first", 64'(alu_first), idx < 0 ? 64'd0 : 64'(q[idx].r1_val));
         check("alu_second", 64'(alu_second), idx < 0 ? 64'd0 : 64'(q[idx].r2_val));
         check("alu_a", 64'(alu_a), idx < 0 ? 64'd0 : 64'(q[idx].pc));
         check("alu_b", 64'(alu_b), idx < 0 ? 64'd0 : 64'(q[idx].imm));
`ifdef BRANCH_SCHED_PERF_EN
         check("perf_issue", 64'(perf_issue_cnt), 64'(m_issue_cnt));
         check("perf_stall", 64'(perf_stall_cnt), 64'(m_stall_cnt));
`endif
      end
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_res_valid = 0; m_res_tag = '0; m_res_taken = 0; m_res_target = '0;
         m_issue_cnt = '0; m_stall_cnt = '0;
         m_known = 1;
      end else begin
         any_rdy = 0;
         foreach (q[i]) if (q[i].r1_rdy && q[i].r2_rdy) any_rdy = 1;
         if (any_rdy && m_res_valid && !res_ready) m_stall_cnt++;
         if (!flush && idx >= 0) m_issue_cnt++;
         if (flush) begin
            q.delete();
            m_res_valid = 0; m_res_tag = '0; m_res_taken = 0; m_res_target = '0;
         end else begin
            fire = alloc_valid && (q.size() < DEPTH);
            if (idx >= 0) begin
               m_res_valid  = 1;
               m_res_tag    = q[idx].tag;
               m_res_taken  = br_taken(q[idx].op, q[idx].r1_val, q[idx].r2_val);
               m_res_target = q[idx].pc + q[idx].imm;
            end else if (m_res_valid && res_ready) begin
               m_res_valid = 0;
            end
            foreach (q[i]) begin
               if (cdb_valid && !q[i].r1_rdy && q[i].r1_tag == cdb_tag) begin
                  q[i].r1_rdy = 1; q[i].r1_val = cdb_value;
               end
               if (cdb_valid && !q[i].r2_rdy && q[i].r2_tag == cdb_tag) begin
                  q[i].r2_rdy = 1; q[i].r2_val = cdb_value;
               end
            end
            if (idx >= 0) q.delete(idx);
            if (fire) begin
               e.op = alloc_op; e.tag = alloc_rob_tag; e.pc = alloc_pc; e.imm = alloc_imm;
               e.r1_tag = alloc_rs1_tag; e.r2_tag = alloc_rs2_tag;
               e.r1_rdy = alloc_rs1_rdy || (cdb_valid && cdb_tag == alloc_rs1_tag);
               e.r1_val = alloc_rs1_rdy ? alloc_rs1_val : cdb_value;
               e.r2_rdy = alloc_rs2_rdy || (cdb_valid && cdb_tag == alloc_rs2_tag);
               e.r2_val = alloc_rs2_rdy ? alloc_rs2_val : cdb_value;
               q.push_back(e);
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      rst = 0; flush = 0; alloc_valid = 0; alloc_op = 3'b000; alloc_rob_tag = '0;
      alloc_pc = '0; alloc_imm = '0;
      alloc_rs1_rdy = 0; alloc_rs1_tag = '0; alloc_rs1_val = '0;
      alloc_rs2_rdy = 0; alloc_rs2_tag = '0; alloc_rs2_val = '0;
      cdb_valid = 0; cdb_tag = '0; cdb_value = '0; res_ready = 1;
   endtask

   task automatic alloc(logic [2:0] op, logic [TAG_W-1:0] tag, logic [31:0] pc, logic [31:0] imm,
                        logic r1r, logic [TAG_W-1:0] r1t, logic [31:0] r1v,
                        logic r2r, logic [TAG_W-1:0] r2t, logic [31:0] r2v);
      alloc_valid = 1; alloc_op = op; alloc_rob_tag = tag; alloc_pc = pc; alloc_imm = imm;
      alloc_rs1_rdy = r1r; alloc_rs1_tag = r1t; alloc_rs1_val = r1v;
      alloc_rs2_rdy = r2r; alloc_rs2_tag = r2t; alloc_rs2_val = r2v;
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'd5;
         4: return 32'h7FFF_FFFF;
         5: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [2:0] pick_op();
      logic [2:0] ops [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
      return ops[$urandom_range(0, 5)];
   endfunction

   initial begin
      int rdy_pct;
      idle();
      rst = 1;
      cycle();
      cycle();
      rst = 0;
      check("rst_alloc_ready", 64'(alloc_ready), 64'd1);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_res_target", 64'(res_target), 64'd0);

      // beq 5==5 at pc 0x100, imm 0x20
      alloc(3'b000, 4'd1, 32'h100, 32'h20, 1, 4'd0, 32'd5, 1, 4'd0, 32'd5);
      cycle();
      idle();
      check("t1_alu_a", 64'(alu_a), 64'h100);
      cycle();
      check("t1_valid", 64'(res_valid), 64'd1);
      check("t1_taken", 64'(res_taken), 64'd1);
      check("t1_target", 64'(res_target), 64'h120);

      // bne with rs1 captured from a same-cycle CDB broadcast
      alloc(3'b001, 4'd4, 32'h200, 32'h8, 0, 4'd3, 32'd0, 1, 4'd0, 32'd9);
      cdb_valid = 1; cdb_tag = 4'd3; cdb_value = 32'd9;
      cycle();
      idle();
      cycle();
      check("t3_valid", 64'(res_valid), 64'd1);
      check("t3_tag", 64'(res_rob_tag), 64'd4);
      check("t3_taken", 64'(res_taken), 64'd0);

      // Flush with three waiting entries and a held result
      res_ready = 0;
      alloc(3'b000, 4'd5, 32'h300, 32'h4, 1, 4'd0, 32'd1, 1, 4'd0, 32'd1);
      cycle();
      for (int i = 0; i < 4; i++) begin
         alloc(3'b110, 4'(6 + i), 32'h400, 32'h4, 0, 4'd12, 32'd0, 1, 4'd0, 32'd2);
         res_ready = 0;
         cycle();
      end
      idle();
      res_ready = 0;
      flush = 1;
      cycle();
      idle();
      check("t6_valid", 64'(res_valid), 64'd0);
      check("t6_alloc_ready", 64'(alloc_ready), 64'd1);
      cycle();

      // Random traffic with varying backpressure phases
      for (int c = 0; c < 3000; c++) begin
         rdy_pct = ((c / 200) % 3 == 0) ? 90 : ((c / 200) % 3 == 1) ? 50 : 10;
         idle();
         if ($urandom_range(0, 1) == 1)
            alloc(pick_op(), 4'($urandom), $urandom, 32'($signed($urandom_range(0, 4095)) - 2048),
                  1'($urandom), 4'($urandom_range(0, 3)), pick_val(),
                  1'($urandom), 4'($urandom_range(0, 3)), pick_val());
         cdb_valid = ($urandom_range(0, 99) < 40);
         cdb_tag   = 4'($urandom_range(0, 3));
         cdb_value = pick_val();
         res_ready = ($urandom_range(0, 99) < rdy_pct);
         flush     = ($urandom_range(0, 99) < 2);
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
